// File: rtl/vga_rect_pkg.sv
// Shared definitions for VGA pixel engines: FSM states, command modes and
// resolution-dependent geometry helpers.
package vga_rect_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_DRAW,
        S_DONE
    } state_t;

    localparam logic [1:0] MODE_FILL    = 2'd0;
    localparam logic [1:0] MODE_OUTLINE = 2'd1;
    localparam logic [1:0] MODE_CLEAR   = 2'd2;
    localparam logic [1:0] MODE_RSVD    = 2'd3;

    // Resolution strings are all seven characters, so they fit a 56-bit vector.
    function automatic int res_hres(input logic [55:0] res);
        case (res)
            "320x240": return 320;
            "160x120": return 160;
            default:   return 640;
        endcase
    endfunction

    function automatic int res_vres(input logic [55:0] res);
        case (res)
            "320x240": return 240;
            "160x120": return 120;
            default:   return 480;
        endcase
    endfunction

    function automatic int res_nx(input logic [55:0] res);
        return (res_hres(res) == 320) ? 9 : (res_hres(res) == 160) ? 8 : 10;
    endfunction

    function automatic int res_ny(input logic [55:0] res);
        return (res_vres(res) == 240) ? 8 : (res_vres(res) == 120) ? 7 : 9;
    endfunction

endpackage

// File: rtl/vga_rect_scan.sv
// Raster pixel counters for one rectangle command: holds the bounds, walks
// cx/cy in raster order, skips row interiors in outline mode, flags the last pixel.
module vga_rect_scan #(
    parameter int nX = 10,
    parameter int nY = 9
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic          adv_i,
    input  logic          outline_i,
    input  logic [nX-1:0] xa_i,
    input  logic [nX-1:0] xb_i,
    input  logic [nY-1:0] ya_i,
    input  logic [nY-1:0] yb_i,
    output logic [nX-1:0] cx_o,
    output logic [nY-1:0] cy_o,
    output logic          last_o
);

    logic [nX-1:0] xa_q, xb_q, cx_q, cx_d;
    logic [nY-1:0] ya_q, yb_q, cy_q, cy_d;

    always_ff @(posedge clk_i) begin
        if (load_i) begin
            xa_q <= xa_i;
            xb_q <= xb_i;
            ya_q <= ya_i;
            yb_q <= yb_i;
        end
    end

    // Increments are bounded by xb/yb, so the counters can never wrap.
    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (load_i) begin
            cx_d = xa_i;
            cy_d = ya_i;
        end else if (adv_i) begin
            if (cx_q == xb_q) begin
                cx_d = xa_q;
                if (cy_q != yb_q) cy_d = cy_q + 1'b1;
            end else if (outline_i && cx_q == xa_q && cy_q > ya_q && cy_q < yb_q) begin
                cx_d = xb_q;
            end else begin
                cx_d = cx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

    assign cx_o   = cx_q;
    assign cy_o   = cy_q;
    assign last_o = (cx_q == xb_q) && (cy_q == yb_q);

endmodule

// File: rtl/vga_rect_engine.sv
// Rectangle fill/outline/clear engine producing registered pixel writes for a
// VGA adapter; one command at a time, launched from IDLE by start.
module vga_rect_engine
    import vga_rect_pkg::*;
#(
    parameter logic [55:0] RESOLUTION  = "640x480",
    parameter int          COLOR_DEPTH = 9,
    parameter int          nX          = res_nx(RESOLUTION),
    parameter int          nY          = res_ny(RESOLUTION)
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [nX-1:0]          x0,
    input  logic [nX-1:0]          x1,
    input  logic [nY-1:0]          y0,
    input  logic [nY-1:0]          y1,
    input  logic [COLOR_DEPTH-1:0] color_in,
    input  logic                   hold,
    output logic [nX-1:0]          x,
    output logic [nY-1:0]          y,
    output logic [COLOR_DEPTH-1:0] color,
    output logic                   write,
    output logic                   busy,
    output logic                   done
);

    localparam logic [nX-1:0] XMAX = nX'(res_hres(RESOLUTION) - 1);
    localparam logic [nY-1:0] YMAX = nY'(res_vres(RESOLUTION) - 1);

    function automatic logic [nX-1:0] sat_x(input logic [nX-1:0] v);
        return (v > XMAX) ? XMAX : v;
    endfunction

    function automatic logic [nY-1:0] sat_y(input logic [nY-1:0] v);
        return (v > YMAX) ? YMAX : v;
    endfunction

    state_t                 state_q;
    logic [1:0]             mode_q;
    logic [nX-1:0]          x0_q, x1_q, xa_d, xb_d, cx, x_q;
    logic [nY-1:0]          y0_q, y1_q, ya_d, yb_d, cy, y_q;
    logic [COLOR_DEPTH-1:0] col_q, color_q;
    logic                   write_q, busy_q, done_q, last;

    always_ff @(posedge CLOCK_50) begin
        if (state_q == S_IDLE && start) begin
            mode_q <= mode;
            x0_q   <= x0;
            x1_q   <= x1;
            y0_q   <= y0;
            y1_q   <= y1;
            col_q  <= color_in;
        end
    end

    always_comb begin
        xa_d = sat_x((x0_q < x1_q) ? x0_q : x1_q);
        xb_d = sat_x((x0_q < x1_q) ? x1_q : x0_q);
        ya_d = sat_y((y0_q < y1_q) ? y0_q : y1_q);
        yb_d = sat_y((y0_q < y1_q) ? y1_q : y0_q);
        if (mode_q == MODE_CLEAR) begin
            xa_d = '0;
            ya_d = '0;
            xb_d = XMAX;
            yb_d = YMAX;
        end
    end

    vga_rect_scan #(
        .nX(nX),
        .nY(nY)
    ) u_scan (
        .clk_i     (CLOCK_50),
        .rst_i     (reset),
        .load_i    (state_q == S_SETUP),
        .adv_i     (state_q == S_DRAW && !hold),
        .outline_i (mode_q == MODE_OUTLINE),
        .xa_i      (xa_d),
        .xb_i      (xb_d),
        .ya_i      (ya_d),
        .yb_i      (yb_d),
        .cx_o      (cx),
        .cy_o      (cy),
        .last_o    (last)
    );

    // busy drops together with the done pulse so it covers every visible write.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            write_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
        end else begin
            write_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_SETUP;
                        busy_q  <= 1'b1;
                    end
                end
                S_SETUP: state_q <= S_DRAW;
                S_DRAW: begin
                    if (!hold) begin
                        write_q <= 1'b1;
                        x_q     <= cx;
                        y_q     <= cy;
                        color_q <= col_q;
                        if (last) state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign x     = x_q;
    assign y     = y_q;
    assign color = color_q;
    assign write = write_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_vga_rect_engine.sv
// Scoreboard bench for vga_rect_engine at 160x120 (6-bit color) and 320x240 (9-bit color).
module tb_vga_rect_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       s_start = 0, s_hold = 0;
    logic [1:0] s_mode = 0;
    logic [7:0] s_x0 = 0, s_x1 = 0, s_x;
    logic [6:0] s_y0 = 0, s_y1 = 0, s_y;
    logic [5:0] s_cin = 0, s_color;
    logic       s_write, s_busy, s_done;

    logic       m_start = 0, m_hold = 0;
    logic [1:0] m_mode = 0;
    logic [8:0] m_x0 = 0, m_x1 = 0, m_x;
    logic [7:0] m_y0 = 0, m_y1 = 0, m_y;
    logic [8:0] m_cin = 0, m_color;
    logic       m_write, m_busy, m_done;

    vga_rect_engine #(.RESOLUTION("160x120"), .COLOR_DEPTH(6)) dut_s (
        .CLOCK_50(clk), .reset(rst), .start(s_start), .mode(s_mode),
        .x0(s_x0), .x1(s_x1), .y0(s_y0), .y1(s_y1), .color_in(s_cin), .hold(s_hold),
        .x(s_x), .y(s_y), .color(s_color), .write(s_write), .busy(s_busy), .done(s_done)
    );

    vga_rect_engine #(.RESOLUTION("320x240"), .COLOR_DEPTH(9)) dut_m (
        .CLOCK_50(clk), .reset(rst), .start(m_start), .mode(m_mode),
        .x0(m_x0), .x1(m_x1), .y0(m_y0), .y1(m_y1), .color_in(m_cin), .hold(m_hold),
        .x(m_x), .y(m_y), .color(m_color), .write(m_write), .busy(m_busy), .done(m_done)
    );

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    pix_t exp_s[$];
    pix_t exp_m[$];
    int total = 0, bad = 0;
    int wr_cnt[2]   = '{0, 0};
    int done_cnt[2] = '{0, 0};
    int last_x[2]   = '{0, 0};
    int last_y[2]   = '{0, 0};

    localparam int G_WR = 0, G_BUSY = 1, G_DONE = 2, G_X = 3, G_Y = 4, G_C = 5;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int get(input int sel, input int what);
        case (what)
            G_WR:    return sel ? int'(m_write) : int'(s_write);
            G_BUSY:  return sel ? int'(m_busy)  : int'(s_busy);
            G_DONE:  return sel ? int'(m_done)  : int'(s_done);
            G_X:     return sel ? int'(m_x)     : int'(s_x);
            G_Y:     return sel ? int'(m_y)     : int'(s_y);
            default: return sel ? int'(m_color) : int'(s_color);
        endcase
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Monitors: pop the expected pixel whenever a DUT presents a write.
    always @(negedge clk) begin
        if (!rst) begin
            if (s_write) begin
                wr_cnt[0]++;
                last_x[0] = s_x;
                last_y[0] = s_y;
                check("busy_on_write_s", s_busy, 1);
                if (exp_s.size() == 0) check("unexpected_write_s", 1, 0);
                else begin
                    pix_t e;
                    e = exp_s.pop_front();
                    check("x_s", s_x, e.x);
                    check("y_s", s_y, e.y);
                    check("color_s", s_color, e.c);
                end
            end
            if (s_done) begin
                done_cnt[0]++;
                check("busy_at_done_s", s_busy, 0);
                check("pending_at_done_s", exp_s.size(), 0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (m_write) begin
                wr_cnt[1]++;
                last_x[1] = m_x;
                last_y[1] = m_y;
                check("busy_on_write_m", m_busy, 1);
                if (exp_m.size() == 0) check("unexpected_write_m", 1, 0);
                else begin
                    pix_t e;
                    e = exp_m.pop_front();
                    check("x_m", m_x, e.x);
                    check("y_m", m_y, e.y);
                    check("color_m", m_color, e.c);
                end
            end
            if (m_done) begin
                done_cnt[1]++;
                check("busy_at_done_m", m_busy, 0);
                check("pending_at_done_m", exp_m.size(), 0);
            end
        end
    end

    // Reference: enumerate the rectangle in raster order, keeping border pixels only for outline.
    task automatic model(input int sel, input int md, input int ax0, input int ax1,
                         input int ay0, input int ay1, input int c, output int n);
        int hres, vres, xa, xb, ya, yb;
        hres = sel ? 320 : 160;
        vres = sel ? 240 : 120;
        xa = (ax0 < ax1) ? ax0 : ax1;
        xb = (ax0 < ax1) ? ax1 : ax0;
        ya = (ay0 < ay1) ? ay0 : ay1;
        yb = (ay0 < ay1) ? ay1 : ay0;
        if (xa > hres - 1) xa = hres - 1;
        if (xb > hres - 1) xb = hres - 1;
        if (ya > vres - 1) ya = vres - 1;
        if (yb > vres - 1) yb = vres - 1;
        if (md == 2) begin
            xa = 0;
            ya = 0;
            xb = hres - 1;
            yb = vres - 1;
        end
        n = 0;
        for (int yy = ya; yy <= yb; yy++) begin
            for (int xx = xa; xx <= xb; xx++) begin
                if (md != 1 || yy == ya || yy == yb || xx == xa || xx == xb) begin
                    pix_t p;
                    p.x = xx;
                    p.y = yy;
                    p.c = c;
                    if (sel) exp_m.push_back(p);
                    else exp_s.push_back(p);
                    n++;
                end
            end
        end
    endtask

    task automatic drive(input int sel, input bit st, input int md, input int ax0, input int ax1,
                         input int ay0, input int ay1, input int c);
        if (sel) begin
            m_start = st; m_mode = 2'(md); m_x0 = 9'(ax0); m_x1 = 9'(ax1);
            m_y0 = 8'(ay0); m_y1 = 8'(ay1); m_cin = 9'(c);
        end else begin
            s_start = st; s_mode = 2'(md); s_x0 = 8'(ax0); s_x1 = 8'(ax1);
            s_y0 = 7'(ay0); s_y1 = 7'(ay1); s_cin = 6'(c);
        end
    endtask

    task automatic set_hold(input int sel, input bit h);
        if (sel) m_hold = h;
        else s_hold = h;
    endtask

    // exp_n < 0 means "use the model's count"; hold_at/abort_at act after that many writes.
    task automatic run_cmd(input string name, input int sel, input int md, input int ax0, input int ax1,
                           input int ay0, input int ay1, input int c, input int exp_n,
                           input int hold_at, input int abort_at);
        int n, req_n, w0, d0, cyc;
        bit fin, held;
        model(sel, md, ax0, ax1, ay0, ay1, c, n);
        req_n = (exp_n >= 0) ? exp_n : n;
        w0 = wr_cnt[sel];
        d0 = done_cnt[sel];
        fin = 0;
        held = 0;
        cyc = 0;
        drive(sel, 1, md, ax0, ax1, ay0, ay1, c);
        tick();
        drive(sel, 0, md, ax0, ax1, ay0, ay1, c);
        check({name, "_setup_busy"}, get(sel, G_BUSY), 1);
        check({name, "_setup_nowrite"}, get(sel, G_WR), 0);
        tick();
        check({name, "_lat_nowrite"}, get(sel, G_WR), 0);
        tick();
        check({name, "_lat_first_write"}, get(sel, G_WR), 1);
        while (cyc < 25000 && !fin) begin
            if (done_cnt[sel] != d0) fin = 1;
            else if (abort_at > 0 && wr_cnt[sel] - w0 == abort_at) begin
                rst = 1;
                #1;
                check({name, "_rst_write"}, get(sel, G_WR), 0);
                check({name, "_rst_busy"}, get(sel, G_BUSY), 0);
                check({name, "_rst_done"}, get(sel, G_DONE), 0);
                check({name, "_rst_x"}, get(sel, G_X), 0);
                check({name, "_rst_y"}, get(sel, G_Y), 0);
                check({name, "_rst_color"}, get(sel, G_C), 0);
                if (sel) exp_m.delete();
                else exp_s.delete();
                tick();
                rst = 0;
                repeat (10) tick();
                check({name, "_abort_no_done"}, done_cnt[sel] - d0, 0);
                check({name, "_abort_writes"}, wr_cnt[sel] - w0, abort_at);
                return;
            end else if (hold_at > 0 && !held && wr_cnt[sel] - w0 == hold_at) begin
                set_hold(sel, 1);
                repeat (4) begin
                    tick();
                    check({name, "_hold_nowrite"}, get(sel, G_WR), 0);
                end
                set_hold(sel, 0);
                held = 1;
                cyc += 4;
            end else begin
                tick();
                cyc++;
            end
        end
        if (!fin) check({name, "_timeout"}, 0, 1);
        else begin
            check({name, "_writes"}, wr_cnt[sel] - w0, req_n);
            tick();
            check({name, "_done_one_cycle"}, get(sel, G_DONE), 0);
            check({name, "_done_count"}, done_cnt[sel] - d0, 1);
        end
    endtask

    initial begin
        int rx0, rx1, ry0, ry1, rm, rc;
        repeat (3) tick();
        for (int s = 0; s < 2; s++) begin
            check("reset_write", get(s, G_WR), 0);
            check("reset_busy", get(s, G_BUSY), 0);
            check("reset_done", get(s, G_DONE), 0);
            check("reset_x", get(s, G_X), 0);
            check("reset_y", get(s, G_Y), 0);
            check("reset_color", get(s, G_C), 0);
        end
        rst = 0;
        repeat (3) tick();
        check("idle_after_reset", wr_cnt[0] + wr_cnt[1], 0);

        run_cmd("fill_small", 0, 0, 10, 12, 5, 6, 6'h2A, 6, 0, 0);
        check("fill_small_last_x", last_x[0], 12);
        check("fill_small_last_y", last_y[0], 6);

        run_cmd("outline_swapped", 0, 1, 3, 0, 0, 3, 6'h15, 12, 0, 0);
        check("outline_last_x", last_x[0], 3);
        check("outline_last_y", last_y[0], 3);

        run_cmd("outline_vline", 0, 1, 4, 4, 8, 2, 6'h07, 7, 0, 0);
        run_cmd("outline_hline", 0, 1, 9, 2, 3, 3, 6'h31, 8, 0, 0);
        run_cmd("degenerate", 0, 0, 50, 50, 40, 40, 6'h3F, 1, 0, 0);
        run_cmd("reserved_mode", 0, 3, 100, 103, 100, 101, 6'h11, 8, 0, 0);
        run_cmd("fill_clamp_s", 0, 0, 155, 250, 118, 127, 6'h22, 10, 0, 0);

        run_cmd("clamp_320", 1, 0, 310, 400, 235, 255, 9'h1A5, 50, 0, 0);
        check("clamp_last_x", last_x[1], 319);
        check("clamp_last_y", last_y[1], 239);

        for (int i = 0; i < 8; i++) begin
            rm  = $urandom_range(0, 2);
            if (rm == 2) rm = 3;
            rx0 = $urandom_range(0, 255);
            rx1 = rx0 + $urandom_range(0, 12);
            if (rx1 > 255) rx1 = 255;
            ry0 = $urandom_range(0, 127);
            ry1 = ry0 + $urandom_range(0, 6);
            if (ry1 > 127) ry1 = 127;
            rc  = $urandom_range(0, 63);
            if ($urandom_range(0, 1) == 1) run_cmd("rand", 0, rm, rx1, rx0, ry1, ry0, rc, -1, 0, 0);
            else run_cmd("rand", 0, rm, rx0, rx1, ry0, ry1, rc, -1, 0, 0);
        end

        run_cmd("clear_160", 0, 2, 7, 3, 9, 1, 6'h0C, 19200, 0, 0);
        check("clear_last_x", last_x[0], 159);
        check("clear_last_y", last_y[0], 119);

        run_cmd("hold_mid_row", 0, 0, 20, 29, 10, 11, 6'h2D, 20, 4, 0);
        run_cmd("abort", 0, 0, 0, 9, 0, 9, 6'h19, -1, 0, 3);
        run_cmd("after_abort", 0, 0, 5, 7, 5, 5, 6'h33, 3, 0, 0);
        check("after_abort_last_x", last_x[0], 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
